// File: rtl/pc_fetch.sv
// Instruction fetch unit: next-PC pointer, single outstanding memory request,
// and a 2-entry in-order buffer of {instruction, address} for decode.
module pc_fetch #(
    parameter logic [7:0] RESET_PC = 8'h04,
    parameter logic [7:0] PC_STEP  = 8'h04,
    parameter int         INSTR_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               br_taken_i,
    input  logic [7:0]         br_target_i,
    output logic               imem_req_o,
    output logic [7:0]         imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ins_valid_o,
    output logic [INSTR_W-1:0] ins_data_o,
    output logic [7:0]         ins_pc_o,
    input  logic               dec_ready_i,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_IDLE  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         addr_q, addr_d;
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, wr_ptr_q;
    logic               misalign_q;
    logic [INSTR_W-1:0] data_q [2];
    logic [7:0]         dpc_q  [2];

    logic       req_s, ack_s, pop_s;
    logic       push_s, pop_en_s, flush_s;
    logic [7:0] tgt_s;

    // Next-state, pointer update and buffer control; a taken branch overrides all else.
    always_comb begin
        req_s    = (state_q != S_IDLE);
        ack_s    = imem_ack_i & req_s;
        pop_s    = (count_q != 2'd0) & dec_ready_i;
        tgt_s    = {br_target_i[7:2], 2'b00};
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        push_s   = 1'b0;
        pop_en_s = 1'b0;
        flush_s  = 1'b0;
        if (br_taken_i) begin
            flush_s = 1'b1;
            pc_d    = tgt_s;
            if (req_s && !ack_s) begin
                // The dropped request stays on the bus until memory answers it.
                state_d = S_FLUSH;
            end else begin
                state_d = S_REQ;
                addr_d  = tgt_s;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    pop_en_s = pop_s;
                    if (ack_s) begin
                        push_s = 1'b1;
                        pc_d   = pc_q + PC_STEP;
                        addr_d = pc_q + PC_STEP;
                        if ((count_q - {1'b0, pop_s}) == 2'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_IDLE: begin
                    pop_en_s = pop_s;
                    if (pop_s) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (ack_s) begin
                        state_d = S_REQ;
                        addr_d  = pc_q;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
                default: begin
                    state_d = S_REQ;
                    addr_d  = pc_q;
                end
            endcase
        end
        if (flush_s) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_en_s};
        end
    end

    // Control state, pointers and buffer occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            misalign_q <= br_taken_i & (br_target_i[1:0] != 2'b00);
            if (flush_s) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                rd_ptr_q <= rd_ptr_q ^ pop_en_s;
                wr_ptr_q <= wr_ptr_q ^ push_s;
            end
        end
    end

    // Buffer storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            data_q[wr_ptr_q] <= imem_rdata_i;
            dpc_q[wr_ptr_q]  <= addr_q;
        end
    end

    assign imem_req_o  = req_s & ~rst_i;
    assign imem_addr_o = addr_q;
    assign ins_valid_o = (count_q != 2'd0);
    assign ins_data_o  = data_q[rd_ptr_q];
    assign ins_pc_o    = dpc_q[rd_ptr_q];
    assign misalign_o  = misalign_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h04, the address of the first fetch after reset (main).
REQ-002 Parameter PC_STEP, default 4, the byte increment between sequential instructions.
REQ-003 Parameter INSTR_W, default 32, the instruction word width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 br_taken  in  1  branch-taken flag from the branch unit (senable); level, sampled every cycle.
REQ-007 br_target  in  8  branch destination from the branch unit (pc); valid when br_taken=1.
REQ-008 imem_req  out  1  instruction-memory fetch request.
REQ-009 imem_addr  out  8  fetch byte address.
REQ-010 imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  in  INSTR_W  fetched instruction word.
REQ-012 ins_valid  out  1  buffer head holds a valid instruction for decode.
REQ-013 ins_data  out  INSTR_W  instruction at the buffer head.
REQ-014 ins_pc  out  8  address of ins_data.
REQ-015 dec_ready  in  1  decode accepts the head; a pop occurs when ins_valid=1 and dec_ready=1.
REQ-016 misalign  out  1  one-cycle pulse when a taken branch had br_target[1:0]!=0.

Function
REQ-017 pc_fetch SHALL hold a next-fetch pointer pc (8 b), a registered imem_addr, a 2-entry in-order FIFO of {instr, addr}, and an FSM with states REQ, IDLE and FLUSH.
REQ-018 imem_req SHALL be 1 exactly in states REQ and FLUSH; imem_addr SHALL stay stable from assertion until the imem_ack cycle.
REQ-019 In REQ with imem_ack=1 and br_taken=0: push {imem_rdata, imem_addr}; pc <= pc+PC_STEP mod 256; imem_addr <= new pc; go IDLE if the resulting count is 2, else stay REQ.
REQ-020 The push/ack latency SHALL be 1: an ack in cycle N into an empty FIFO gives ins_valid=1 in cycle N+1.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, and ordering SHALL be preserved.
REQ-022 In IDLE (count=2, no request), a pop SHALL move the FSM to REQ, with imem_req=1 in the next cycle.
REQ-023 When br_taken=1, the FIFO SHALL be cleared (ins_valid=0 next cycle), and pc and the next imem_addr SHALL take {br_target[7:2],2'b00}. br_taken SHALL override any same-cycle push or pop.
REQ-024 Branch in REQ without a same-cycle ack: go FLUSH, keep the old imem_addr and imem_req=1 until ack, discard that data, then go REQ at the target.
REQ-025 Branch in REQ with a same-cycle ack: discard the data and stay REQ at the target. Branch in IDLE: go REQ at the target.
REQ-026 Branch in FLUSH: update the target only; remain in FLUSH until the outstanding ack.
REQ-027 misalign SHALL pulse the cycle after a taken branch with br_target[1:0]!=0; otherwise misalign SHALL be 0.
REQ-028 Wrap-around: the pc increment 8'hFC+4 SHALL yield 8'h00, with no flag.
REQ-029 ins_data and ins_pc SHALL be driven from the FIFO head; their value when ins_valid=0 is don't-care.

Reset
REQ-030 With rst=1 at a clock edge: pc=RESET_PC, imem_addr=RESET_PC, FIFO count=0, ins_valid=0, misalign=0, state=REQ.
REQ-031 With rst=1: imem_req=0. In the first cycle after rst falls: imem_req=1 with imem_addr=RESET_PC.
REQ-032 Reset during an outstanding request SHALL abandon it with no FLUSH; the memory SHALL tolerate the dropped request.

Verification
REQ-033 Reset then ack every cycle, dec_ready=1 -> ins_pc sequence 04,08,0C,10..., one per cycle after the first 1-cycle latency.
REQ-034 dec_ready=0 with ack always 1 -> exactly two pushes (04,08), then imem_req=0 (IDLE). Raise dec_ready -> head 04 pops, and imem_req=1 at 0C next cycle.
REQ-035 Request at 10 outstanding (ack=0), br_taken=1 with target 38 -> FLUSH. A later ack at 10 is discarded. Next request is at 38, and ins_pc=38 is the first to appear.
REQ-036 Branch to 50 in the same cycle as ack at 14 and a pop -> FIFO empty next cycle, 14 never appears at ins_pc, and the next request is at 50.
REQ-037 pc at FC with ack -> next imem_addr=00. A branch to 0x71 -> misalign pulse, and fetch at 0x70.
REQ-038 rst asserted mid-FLUSH -> all outputs at reset values next cycle, and a clean restart at RESET_PC.
